// File: rtl/pool_max_onehot_sel.sv
// rtl/pool_max_onehot_sel.sv - streaming max-pooling selector with one-hot max position
//
// Accepts a window of N samples (one per in_valid & in_ready beat), tracks the
// running maximum and its index, and presents the maximum plus a one-hot
// position vector for the downstream one-hot-to-binary encoder.
//
// Parameters:
//   DATA_W      pixel sample width
//   N           samples per window / width of out_onehot (2..16)
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   in_valid/in_ready        input handshake
//   in_data, in_sof          sample and start-of-window marker
//   out_valid/out_ready      result handshake
//   out_max, out_onehot      window maximum and its one-hot position
//   sof_err                  sticky: in_sof seen mid-window
// Build option:
//   POOL_SIGNED_CMP_EN       when defined, samples compare as two's-complement
module pool_max_onehot_sel #(
    parameter int DATA_W = 8,
    parameter int N      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [N-1:0]      out_onehot,
    output logic              sof_err
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  run_idx_q, run_idx_d;
    logic [DATA_W-1:0] run_max_q, run_max_d;
    logic [DATA_W-1:0] out_max_q, out_max_d;
    logic [N-1:0]      out_onehot_q, out_onehot_d;
    logic              sof_err_q, sof_err_d;

    logic              accept;
    logic              restart;
    logic              gt;
    logic              last_beat;
    logic [DATA_W-1:0] new_max;
    logic [CNT_W-1:0]  new_idx;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        run_idx_d    = run_idx_q;
        run_max_d    = run_max_q;
        out_max_d    = out_max_q;
        out_onehot_d = out_onehot_q;
        sof_err_d    = sof_err_q;

        accept  = in_valid && (state_q == ACCUM);
        // Either the first beat of a window or an in_sof that abandons the
        // partial window: both seed the running max at index 0.
        restart = (count_q == '0) || in_sof;

`ifdef POOL_SIGNED_CMP_EN
        gt = $signed(in_data) > $signed(run_max_q);
`else
        gt = in_data > run_max_q;
`endif

        // Strict greater-than keeps the lowest index on ties.
        if (restart) begin
            new_max = in_data;
            new_idx = '0;
        end else if (gt) begin
            new_max = in_data;
            new_idx = count_q;
        end else begin
            new_max = run_max_q;
            new_idx = run_idx_q;
        end

        // An in_sof restart can never complete a window since N >= 2.
        last_beat = !in_sof && (count_q == LAST_IDX);

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    run_max_d = new_max;
                    run_idx_d = new_idx;
                    if (in_sof && (count_q != '0)) begin
                        sof_err_d = 1'b1;
                    end
                    if (last_beat) begin
                        count_d      = '0;
                        state_d      = HOLD;
                        out_max_d    = new_max;
                        out_onehot_d = ONE_HOT0 << new_idx;
                    end else if (restart) begin
                        count_d = CNT_W'(1);
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            count_q      <= '0;
            run_idx_q    <= '0;
            run_max_q    <= '0;
            out_max_q    <= '0;
            out_onehot_q <= '0;
            sof_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            run_idx_q    <= run_idx_d;
            run_max_q    <= run_max_d;
            out_max_q    <= out_max_d;
            out_onehot_q <= out_onehot_d;
            sof_err_q    <= sof_err_d;
        end
    end

    assign in_ready   = (state_q == ACCUM);
    assign out_valid  = (state_q == HOLD);
    assign out_max    = out_max_q;
    assign out_onehot = out_onehot_q;
    assign sof_err    = sof_err_q;

endmodule

// File: tb/tb_pool_max_onehot_sel.sv
// tb/tb_pool_max_onehot_sel.sv - directed table-driven bench for pool_max_onehot_sel
module tb_pool_max_onehot_sel;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_sof;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_max;
    logic [15:0] out_onehot;
    logic        sof_err;

    int n_vec = 0;
    int n_err = 0;

    pool_max_onehot_sel #(.DATA_W(8), .N(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_max    (out_max),
        .out_onehot (out_onehot),
        .sof_err    (sof_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0][7:0] d;
        logic             sof0;
        logic             gap;
        logic [7:0]       exp_max;
        logic [15:0]      exp_oh;
    } win_t;

    win_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic sof);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send_window(input logic [15:0][7:0] d, input logic sof0, input logic gap);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("not_early_valid", {31'd0, out_valid}, 32'd0);
            beat(d[i], (i == 0) ? sof0 : 1'b0);
            if (gap && i != 15) begin
                in_data = 8'hFF;
                tick();
            end
        end
    endtask

    task automatic chk_result(input string tag, input logic [7:0] m, input logic [15:0] oh);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_max"}, {24'd0, out_max}, {24'd0, m});
        chk({tag, "_onehot"}, {16'd0, out_onehot}, {16'd0, oh});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0][7:0] w;

        // window 0: max 0xC8 at index 9
        tbl[0].d = {8'h00, 8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'hC8, 8'h09,
                    8'h08, 8'h06, 8'h02, 8'h05, 8'h04, 8'h01, 8'h07, 8'h03};
        tbl[0].sof0 = 1'b0; tbl[0].gap = 1'b0;
        tbl[0].exp_max = 8'hC8; tbl[0].exp_oh = 16'h0200;
        // window 1: tie of 0x55 at 4 and 11
        for (int i = 0; i < 16; i++) tbl[1].d[i] = 8'(i);
        tbl[1].d[4] = 8'h55; tbl[1].d[11] = 8'h55;
        tbl[1].sof0 = 1'b1; tbl[1].gap = 1'b0;
        tbl[1].exp_max = 8'h55; tbl[1].exp_oh = 16'h0010;
        // window 2: 0x7F at 2, 0x80 at 5
        for (int i = 0; i < 16; i++) tbl[2].d[i] = 8'h01;
        tbl[2].d[2] = 8'h7F; tbl[2].d[5] = 8'h80;
        tbl[2].sof0 = 1'b0; tbl[2].gap = 1'b0;
`ifdef POOL_SIGNED_CMP_EN
        tbl[2].exp_max = 8'h7F; tbl[2].exp_oh = 16'h0004;
`else
        tbl[2].exp_max = 8'h80; tbl[2].exp_oh = 16'h0020;
`endif
        // window 3: all zero, idle gaps between beats
        tbl[3].d = '0;
        tbl[3].sof0 = 1'b0; tbl[3].gap = 1'b1;
        tbl[3].exp_max = 8'h00; tbl[3].exp_oh = 16'h0001;
        // window 4: max at last index
        for (int i = 0; i < 16; i++) tbl[4].d[i] = 8'(i);
        tbl[4].d[15] = 8'hFF;
        tbl[4].sof0 = 1'b1; tbl[4].gap = 1'b0;
        tbl[4].exp_max = 8'hFF; tbl[4].exp_oh = 16'h8000;
        // window 5: max at index 0
        for (int i = 0; i < 16; i++) tbl[5].d[i] = 8'hFE;
        tbl[5].d[0] = 8'hFF;
        tbl[5].sof0 = 1'b0; tbl[5].gap = 1'b0;
        tbl[5].exp_max = 8'hFF; tbl[5].exp_oh = 16'h0001;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_sof = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_max", {24'd0, out_max}, 32'd0);
        chk("rst_onehot", {16'd0, out_onehot}, 32'd0);
        chk("rst_sof_err", {31'd0, sof_err}, 32'd0);

        for (int k = 0; k < 6; k++) begin
            send_window(tbl[k].d, tbl[k].sof0, tbl[k].gap);
            chk_result($sformatf("win%0d", k), tbl[k].exp_max, tbl[k].exp_oh);
            chk($sformatf("win%0d_sof_err", k), {31'd0, sof_err}, 32'd0);
            tick();
            chk($sformatf("win%0d_drop_valid", k), {31'd0, out_valid}, 32'd0);
            chk($sformatf("win%0d_ready_back", k), {31'd0, in_ready}, 32'd1);
            chk($sformatf("win%0d_max_kept", k), {24'd0, out_max}, {24'd0, tbl[k].exp_max});
        end

        // backpressure: hold for 5 cycles with junk offered on the input
        out_ready = 1'b0;
        send_window(tbl[0].d, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            chk_result($sformatf("hold%0d", c), 8'hC8, 16'h0200);
            tick();
        end
        chk_result("hold5", 8'hC8, 16'h0200);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("hold_release_ready", {31'd0, in_ready}, 32'd1);
        chk("hold_release_valid", {31'd0, out_valid}, 32'd0);
        send_window(tbl[1].d, 1'b0, 1'b0);
        chk_result("after_hold", 8'h55, 16'h0010);
        tick();

        // in_sof mid-window discards the partial window
        for (int i = 0; i < 6; i++) beat(8'hF0, 1'b0);
        chk("sof_err_before", {31'd0, sof_err}, 32'd0);
        beat(8'h10, 1'b1);
        chk("sof_err_set", {31'd0, sof_err}, 32'd1);
        for (int i = 1; i < 16; i++) beat(8'(i), 1'b0);
        chk_result("sof_win", 8'h10, 16'h0001);
        tick();
        send_window(tbl[5].d, 1'b0, 1'b0);
        chk_result("sof_sticky_win", 8'hFF, 16'h0001);
        chk("sof_err_sticky", {31'd0, sof_err}, 32'd1);
        tick();

        // reset mid-window: count must restart
        for (int i = 0; i < 8; i++) beat(8'hEE, 1'b0);
        pulse_reset();
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_sof_err", {31'd0, sof_err}, 32'd0);
        chk("rst_mid_max", {24'd0, out_max}, 32'd0);
        send_window(tbl[0].d, 1'b0, 1'b0);
        chk_result("rst_mid_win", 8'hC8, 16'h0200);

        // reset while the result is held
        out_ready = 1'b0;
        tick();
        chk("pre_rst_hold_valid", {31'd0, out_valid}, 32'd1);
        pulse_reset();
        chk("rst_hold_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_hold_onehot", {16'd0, out_onehot}, 32'd0);
        chk("rst_hold_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        w = tbl[1].d;
        send_window(w, 1'b0, 1'b0);
        chk_result("rst_hold_win", 8'h55, 16'h0010);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pool_max_onehot_sel.md
Name: pool_max_onehot_sel

Overview:
- Streaming max-pooling selector. Sits directly upstream of the one-hot-to-binary index encoder.
- Accepts one pooling window of N pixel samples, one per handshake beat.
- Tracks the running maximum and its position.
- Presents the maximum value plus a one-hot position vector. The vector feeds the encoder, which produces the binary max index.

Parameters:
- DATA_W, 8, pixel sample width in bits.
- N, 16, samples per pooling window; also the width of out_onehot. Legal range is 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  sample present on in_data.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  DATA_W  pixel sample.
- in_sof  input  1  start-of-window marker, qualified by in_valid and in_ready.
- out_valid  output  1  window result available.
- out_ready  input  1  downstream consumes the result.
- out_max  output  DATA_W  maximum sample of the window.
- out_onehot  output  N  bit i set when sample i was the maximum; exactly one bit set when out_valid=1.
- sof_err  output  1  sticky flag: in_sof was seen mid-window.

Behaviour:
- Reset is synchronous, active when rst_n=0 at a clk edge. It applies in any state, including mid-window and while out_valid=1.
- After reset:
  - state=ACCUM, count=0.
  - in_ready=1, out_valid=0, out_max=0, out_onehot=0, sof_err=0.
- Accept beat = in_valid & in_ready.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1. out_max and out_onehot stay stable until consumed.
- ACCUM, accept beat with count=0:
  - run_max <= in_data.
  - run_idx <= 0.
  - count <= 1.
- ACCUM, accept beat with count=k>0:
  - If in_data > run_max, then run_max <= in_data and run_idx <= k.
  - count <= k+1.
- Tie rule: strict greater-than. On equal values the lowest index wins.
- Compare: unsigned by default (see Optional Feature).
- ACCUM, accept beat with count=N-1:
  - Apply the update above.
  - Next cycle: state=HOLD, out_valid=1.
  - out_max = final max. out_onehot = 1 << final index.
  - count <= 0.
- Latency: out_valid rises on the clk edge that registers the Nth accepted sample, i.e. one cycle after that sample is presented. No combinational path from in_data to the outputs.
- HOLD with out_ready=1: result consumed; next cycle state=ACCUM and out_valid=0.
  - out_max and out_onehot keep their last values. Downstream must qualify them with out_valid.
- HOLD with out_ready=0: hold all outputs indefinitely. in_ready stays 0.
- No overlap between windows. A minimum of one idle input cycle per window (N accepts + 1 HOLD cycle when out_ready is tied high). Throughput is N samples per N+1 cycles.
- in_sof on an accepted beat:
  - count=0: normal start; no effect.
  - count≠0: discard the partial window. Treat this sample as index 0 (run_max <= in_data, run_idx <= 0, count <= 1) and set sof_err <= 1.
- sof_err clears only on reset.
- in_sof is optional upstream. Tying it to 0 gives free-running window framing on the beat count alone.
- in_valid=0 in ACCUM: no state change; the partial window is held.

Optional Feature:
- Macro: POOL_SIGNED_CMP_EN.
- Defined: in_data, run_max and out_max are treated as two's-complement. The compare is signed. The reset value of out_max stays 0.
- Undefined: unsigned compare. Identical in all other respects.

Test Plan:
- Reset, then stream N=16 samples 3,7,1,...,0 with the max 0xC8 at index 9, out_ready=1 → out_valid=1 one cycle after the 16th beat, out_max=0xC8, out_onehot=16'h0200, then out_valid=0 and in_ready=1 the next cycle.
- Window with 0x55 at indices 4 and 11, all others smaller → out_onehot=16'h0010 (lowest index wins).
- Complete window with out_ready=0 for 5 cycles → in_ready=0 and outputs stable for all 5 cycles. Raise out_ready → accepts resume the cycle after.
- Send 6 samples, then a sample with in_sof=1 and value 0x10 followed by 15 samples < 0x10 → sof_err=1, out_max=0x10, out_onehot=16'h0001.
- Assert rst_n=0 after 8 samples and again while out_valid=1 → next cycle out_valid=0, out_onehot=0, count restarts; a following full window gives the correct result.
- With POOL_SIGNED_CMP_EN, window of 0x7F at index 2 and 0x80 at index 5 → out_max=0x7F, out_onehot=16'h0004. Without the macro → out_max=0x80, out_onehot=16'h0020.
